icb_sram_slave: RTL and testbench
=================================

# icb_sram_slave

ICB responder that terminates one ICB port with a word-addressed on-chip SRAM, serving as the output/feature buffer written and read by the convolution engine and other ICB initiators on the SoC bus. It accepts one command per cycle, performs byte-masked writes or word reads against its local array, and returns exactly one in-order response per accepted command through a 2-entry response buffer. This lets the initiator keep issuing commands while its response side is briefly stalled.

## Interface
Parameters:
- BASE_ADDR, 32'h6000_0000, byte address of word 0
- DEPTH, 4096, number of 32-bit words (power of two, ≥ 2)
- AW, 32, ICB address width
- DW, 32, ICB data width (fixed 32; wmask is DW/8)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid & ready
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  4  byte enables, bit i writes wdata[8i+7:8i]
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response consumed when valid & ready
- icb_rsp_rdata  out  DW  read data (0 for writes and errors)
- icb_rsp_err  out  1  1 = address out of range

## Operation
- The command handshake is `cmd_fire = icb_cmd_valid & icb_cmd_ready`.
- The response handshake is `rsp_fire = icb_rsp_valid & icb_rsp_ready`.
- Decode:
  - offset = addr − BASE_ADDR; in range iff addr ≥ BASE_ADDR and offset < 4·DEPTH.
  - Word index = offset[log2(DEPTH)+1:2].
  - addr[1:0] is ignored, so misaligned addresses access the containing word.
- Write, in range: on cmd_fire, each byte with wmask bit set is updated. wmask = 0 changes nothing. The response is {rdata=0, err=0}.
- Read, in range: on cmd_fire, the word is read from the array and stored in the response buffer as {rdata=word, err=0}.
- Out of range, read or write: no array access. The response is {rdata=0, err=1}.
- Response buffer: 2-entry FIFO with occupancy count 0..2.
  - Push on cmd_fire; pop on rsp_fire.
  - Push and pop in the same cycle leave the count unchanged.
- icb_cmd_ready = (count < 2). It is registered-state only and has no combinational path from icb_rsp_ready.
- icb_rsp_valid = (count > 0). rdata/err are the head entry; they are stable while valid & !ready.
- Responses are strictly in command order, one per command; none is dropped or duplicated.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- Memory contents are not reset. Only control state (FIFO pointers, count) is reset.

## Timing
- Reset values: icb_cmd_ready=1, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, count=0.
- Latency: cmd_fire at edge T gives icb_rsp_valid high in the cycle after T.
- With icb_rsp_ready held at 1, throughput is 1 command/cycle sustained and count stays ≤ 1.
- icb_rsp_ready low:
  - Two further commands are accepted, then icb_cmd_ready drops.
  - It rises again in the cycle after the first rsp_fire.
- Full FIFO with simultaneous cmd_valid and rsp_fire: the command is not accepted that cycle, because ready depends on the current count only.
- FIFO pointers wrap modulo 2.
- Reset asserted mid-transfer: pending responses are discarded immediately (async), valid drops without waiting for the clock, and no array write occurs on a command in flight at reset.

## Structure
- Package icb_pkg:
  - ICB_AW/ICB_DW constants.
  - rsp entry typedef {rdata[31:0], err}.
  - Address-in-range function.
- Sub-module icb_rsp_fifo: 2-entry synchronous FIFO of rsp entries with count, full and empty outputs, and async active-low reset.
- Top level: decode, byte-masked array write, array read, FIFO push.

## Test plan
- After reset, write 0x6000_0010 with data 0xA1B2C3D4, wmask 4'hF, then read the same address → read rsp rdata=0xA1B2C3D4, err=0; write rsp rdata=0, err=0.
- Write 0x1122_3344 mask 4'hF, then 0xFFFF_FFFF mask 4'b0101 to 0x6000_0020, then read → 0x11FF_33FF.
- Back-to-back reads of 0x6000_0000..0x6000_003C with rsp_ready=1 → 16 responses on 16 consecutive cycles, in order, cmd_ready never low.
- rsp_ready=0, issue 3 reads → cmd_ready low after 2 accepts. Raise rsp_ready → third accepted the cycle after the first rsp_fire; data order preserved.
- Read 0x5FFF_FFFC and write 0x6000_4000 (DEPTH=4096) → both give err=1, rdata=0; a subsequent read of 0x6000_0000 is unchanged.
- Assert rst_n low with 2 responses pending → rsp_valid=0 and cmd_ready=1 immediately; previously written memory data is still readable after release.

Source files
------------

// File: rtl/icb_pkg.sv
// rtl/icb_pkg.sv - shared ICB constants, response entry type and address decode helper
// Contents:
//   ICB_AW, ICB_DW       bus address/data widths
//   icb_rsp_t            one buffered response {rdata, err}
//   icb_addr_in_range()  1 when addr falls inside [base, base + span_bytes)
package icb_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;

  typedef struct packed {
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_t;

  // span_bytes is one bit wider than the address so a window reaching the
  // top of the address space can still be expressed.
  function automatic logic icb_addr_in_range(input logic [ICB_AW-1:0] addr,
                                             input logic [ICB_AW-1:0] base,
                                             input logic [ICB_AW:0]   span_bytes);
    logic [ICB_AW-1:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < span_bytes);
  endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// rtl/icb_rsp_fifo.sv - 2-entry response buffer between array access and ICB response channel
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full)
//   push_data    response entry to enqueue
//   pop          drop the head entry (ignored when empty)
//   head         oldest entry, valid while !empty
//   count        occupancy 0..2
//   full, empty  occupancy flags
module icb_rsp_fifo
  import icb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  icb_rsp_t push_data,
  input  logic     pop,
  output icb_rsp_t head,
  output logic [1:0] count,
  output logic     full,
  output logic     empty
);

  icb_rsp_t entries [2];
  logic     wr_ptr;
  logic     rd_ptr;
  logic     do_push;
  logic     do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/icb_sram_slave.sv
// rtl/icb_sram_slave.sv - ICB responder backed by a word-addressed on-chip SRAM
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   icb_cmd_valid/ready            command handshake (ready = buffer not full)
//   icb_cmd_addr                   byte address, low two bits ignored
//   icb_cmd_read                   1 = read, 0 = write
//   icb_cmd_wdata, icb_cmd_wmask   write data and byte enables
//   icb_rsp_valid/ready            response handshake (valid = buffer not empty)
//   icb_rsp_rdata                  read data, 0 for writes and errors
//   icb_rsp_err                    address outside the SRAM window
module icb_sram_slave
  import icb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          AW        = 32,
  parameter int          DW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            icb_cmd_valid,
  output logic            icb_cmd_ready,
  input  logic [AW-1:0]   icb_cmd_addr,
  input  logic            icb_cmd_read,
  input  logic [DW-1:0]   icb_cmd_wdata,
  input  logic [DW/8-1:0] icb_cmd_wmask,
  output logic            icb_rsp_valid,
  input  logic            icb_rsp_ready,
  output logic [DW-1:0]   icb_rsp_rdata,
  output logic            icb_rsp_err
);

  localparam int            IW         = $clog2(DEPTH);
  localparam logic [AW:0]   SPAN_BYTES = (AW+1)'(DEPTH) << 2;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] offset;
  logic [IW-1:0] word_idx;
  logic          in_range;
  logic          cmd_fire;
  logic          rsp_fire;
  logic          wr_en;
  logic [DW-1:0] rd_word;

  icb_rsp_t      push_entry;
  icb_rsp_t      head_entry;
  logic [1:0]    fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Decode: misaligned addresses land in the containing word.
  assign offset   = icb_cmd_addr - BASE_ADDR;
  assign word_idx = IW'(offset >> 2);
  assign in_range = icb_addr_in_range(icb_cmd_addr, BASE_ADDR, SPAN_BYTES);

  // Ready/valid come from buffer occupancy only, so there is no combinational
  // path from icb_rsp_ready to icb_cmd_ready.
  assign icb_cmd_ready = !fifo_full;
  assign icb_rsp_valid = (fifo_count != 2'd0);
  assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;
  assign rsp_fire      = icb_rsp_valid && icb_rsp_ready;
  assign wr_en         = cmd_fire && !icb_cmd_read && in_range;

  // The array lives in the async-reset domain only so that a command
  // presented while reset is held cannot write it; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_en) begin
      for (int b = 0; b < DW/8; b++) begin
        if (icb_cmd_wmask[b]) begin
          mem[word_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read is combinational off the array and captured into the buffer at
  // cmd_fire, so a read following a write on the next cycle sees new data.
  assign rd_word          = mem[word_idx];
  assign push_entry.rdata = (icb_cmd_read && in_range) ? rd_word : '0;
  assign push_entry.err   = !in_range;

  icb_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_fire),
    .push_data (push_entry),
    .pop       (rsp_fire),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign icb_rsp_rdata = fifo_empty ? '0 : head_entry.rdata;
  assign icb_rsp_err   = fifo_empty ? 1'b0 : head_entry.err;

endmodule

// File: tb/tb_icb_sram_slave.sv
// tb/tb_icb_sram_slave.sv - self-checking bench for icb_sram_slave
module tb_icb_sram_slave;

  localparam logic [31:0] BASE  = 32'h6000_0000;
  localparam int          DEPTH = 4096;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;

  rsp_t        q[$];
  rsp_t        got[$];
  logic [31:0] mm [int];

  icb_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: a command is judged from the address window and a word map.
  function automatic rsp_t model_rsp(logic rd, logic [31:0] a, logic [31:0] d, logic [3:0] m);
    longint unsigned off;
    int              idx;
    logic [31:0]     w;
    if (a < BASE) return {32'h0, 1'b1};
    off = longint'(a) - longint'(BASE);
    if (off >= 4 * DEPTH) return {32'h0, 1'b1};
    idx = int'(off / 4);
    w = mm.exists(idx) ? mm[idx] : 32'h0;
    if (rd) return {w, 1'b0};
    for (int b = 0; b < 4; b++)
      if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mm[idx] = w;
    return {32'h0, 1'b0};
  endfunction

  // Model: queue of outstanding responses, capacity 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit   cf;
      bit   rf;
      rsp_t r;
      cf = icb_cmd_valid && (q.size() < 2);
      rf = (q.size() > 0) && icb_rsp_ready;
      if (cf) r = model_rsp(icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask);
      if (rf) void'(q.pop_front());
      if (cf) q.push_back(r);
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", icb_cmd_ready, q.size() < 2);
      chk("rsp_valid", icb_rsp_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("rsp_rdata", icb_rsp_rdata, q[0].d);
        chk("rsp_err", icb_rsp_err, q[0].e);
      end
      if (icb_rsp_valid && icb_rsp_ready) got.push_back({icb_rsp_rdata, icb_rsp_err});
    end
  end

  task automatic do_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic acc;
    int   n;
    acc = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = icb_cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("cmd_accept_timeout", acc, 1);
    stall_cycles += n;
    icb_cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 100 && got.size() < n; i++) @(posedge clk);
    chk("rsp_count", got.size(), n);
  endtask

  task automatic drain();
    icb_rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    got.delete();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h6000_3FFC + $urandom_range(0, 3);
      1:       return 32'h6000_4000 + $urandom_range(0, 7);
      2:       return 32'h5FFF_FFFC + $urandom_range(0, 3);
      3:       return $urandom() | 32'h8000_0000;
      default: return BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    icb_rsp_ready = 1'b1;
    #1;
    chk("rst_cmd_ready", icb_cmd_ready, 1);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 0);
    chk("rst_rsp_err", icb_rsp_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Known contents for the window used by directed and random traffic.
    for (int i = 0; i < 32; i++) do_cmd(0, BASE + 4 * i, 32'hC0DE_0000 + i, 4'hF);
    do_cmd(0, 32'h6000_3FFC, 32'h5A5A_0FFF, 4'hF);
    drain();

    // Back-to-back reads, one per cycle.
    stall_cycles = 0;
    for (int i = 0; i < 16; i++) do_cmd(1, BASE + 4 * i, 0, 0);
    chk("b2b_stalls", stall_cycles, 0);
    wait_got(16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("b2b_data", got[i], {32'hC0DE_0000 + i, 1'b0});
    drain();

    // Stalled response side: two accepts, then ready drops.
    icb_rsp_ready = 1'b0;
    do_cmd(1, BASE + 0, 0, 0);
    do_cmd(1, BASE + 4, 0, 0);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = BASE + 8;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready_low", icb_cmd_ready, 0);
    end
    @(posedge clk);
    #1 icb_rsp_ready = 1'b1;
    @(negedge clk);
    chk("ready_before_pop", icb_cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_pop", icb_cmd_ready, 1);
    @(posedge clk);
    #1 icb_cmd_valid = 1'b0;
    wait_got(3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("stall_order", got[i], {32'hC0DE_0000 + i, 1'b0});
    drain();

    // Write then read, write response carries zero data.
    do_cmd(0, 32'h6000_0010, 32'hA1B2C3D4, 4'hF);
    do_cmd(1, 32'h6000_0010, 0, 0);
    wait_got(2);
    if (got.size() >= 2) begin
      chk("wr_rsp", got[0], {32'h0, 1'b0});
      chk("raw_rsp", got[1], {32'hA1B2C3D4, 1'b0});
    end
    drain();

    // Byte-masked merge.
    do_cmd(0, 32'h6000_0020, 32'h1122_3344, 4'hF);
    do_cmd(0, 32'h6000_0020, 32'hFFFF_FFFF, 4'b0101);
    do_cmd(1, 32'h6000_0022, 0, 0);
    wait_got(3);
    if (got.size() >= 3) chk("mask_merge", got[2], {32'h11FF_33FF, 1'b0});
    drain();

    // Out-of-range on both sides of the window.
    do_cmd(1, 32'h5FFF_FFFC, 0, 0);
    do_cmd(0, 32'h6000_4000, 32'hBAD0_BAD0, 4'hF);
    do_cmd(1, 32'h6000_0000, 0, 0);
    wait_got(3);
    if (got.size() >= 3) begin
      chk("oor_low", got[0], {32'h0, 1'b1});
      chk("oor_high", got[1], {32'h0, 1'b1});
      chk("oor_no_alias", got[2], {32'hC0DE_0000, 1'b0});
    end
    drain();

    // Reset with two responses pending and a write presented during reset.
    icb_rsp_ready = 1'b0;
    do_cmd(1, BASE + 0, 0, 0);
    do_cmd(1, BASE + 4, 0, 0);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 32'h6000_0040;
    icb_cmd_wdata = 32'hDEAD_BEEF;
    icb_cmd_wmask = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", icb_rsp_valid, 0);
    chk("async_rst_ready", icb_cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    got.delete();
    do_cmd(1, 32'h6000_0040, 0, 0);
    do_cmd(1, 32'h6000_0010, 0, 0);
    wait_got(2);
    if (got.size() >= 2) begin
      chk("rst_no_write", got[0], {32'hC0DE_0010, 1'b0});
      chk("rst_mem_kept", got[1], {32'hA1B2C3D4, 1'b0});
    end
    drain();

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 800; i++) begin
      icb_cmd_valid = ($urandom_range(0, 3) != 0);
      icb_cmd_read  = $urandom_range(0, 1);
      icb_cmd_addr  = rand_addr();
      icb_cmd_wdata = $urandom();
      icb_cmd_wmask = $urandom_range(0, 15);
      icb_rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    icb_cmd_valid = 1'b0;
    drain();
    chk("final_empty", icb_rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
